pipe_drain_buffer: RTL and testbench

//  Receive end of a fixed-latency, no-backpressure shift pipe. Captures words leaving the pipe
//  (pipe_valid/pipe_data) into a FIFO and drains them to a consumer over valid/ready.

---
 rtl/pipe_drain_buffer_pkg.sv | 9 +
 rtl/pipe_drain_credit.sv | 48 ++++
 rtl/pipe_drain_buffer.sv | 85 ++++++++
 tb/tb_pipe_drain_buffer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_drain_buffer_pkg.sv
// Shared helpers for the pipe drain buffer slice.
package pipe_drain_buffer_pkg;

    // Pointer increment with explicit wrap, so depth need not be a power of two.
    function automatic int wrap_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/pipe_drain_credit.sv
// Credit counter for an issuer feeding a fixed-latency pipe into a bounded buffer.
// Tracks free credits, gates issue_ok and raises a sticky protocol-error flag.
module pipe_drain_credit #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue_valid,
    input  logic [$clog2(DEPTH+1):0]     ret,
    input  logic                         ovf,
    output logic                         issue_ok,
    output logic [$clog2(DEPTH+1)-1:0]   credits,
    output logic                         err
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] r_credits;
    logic          r_err;
    logic          w_issue;
    logic [CW+1:0] w_sum;
    logic [CW-1:0] w_next;

    assign issue_ok = (r_credits != '0);
    assign credits  = r_credits;
    assign err      = r_err;

    // Clamp guards the counter if the receive side misbehaves (e.g. dropped words).
    always_comb begin
        w_issue = issue_valid & issue_ok;
        w_sum   = {2'b00, r_credits} + {1'b0, ret} - {{(CW+1){1'b0}}, w_issue};
        w_next  = (w_sum > (CW+2)'(DEPTH)) ? CW'(DEPTH) : w_sum[CW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_credits <= CW'(DEPTH);
            r_err     <= 1'b0;
        end else begin
            r_credits <= w_next;
            if ((issue_valid & ~issue_ok) | ovf)
                r_err <= 1'b1;
        end
    end

    a_cred_max: assert property (@(posedge clk) disable iff (!rst_n)
        r_credits <= CW'(DEPTH));

endmodule

// File: rtl/pipe_drain_buffer.sv
// Receive end of a no-backpressure shift pipe: FWFT FIFO drained over valid/ready,
// with credit accounting so issued-plus-stored ops never exceed DEPTH.
module pipe_drain_buffer
    import pipe_drain_buffer_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue_valid,
    output logic                         issue_ok,
    input  logic                         pipe_valid,
    input  logic [WIDTH-1:0]             pipe_data,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [$clog2(DEPTH+1)-1:0]   credits,
    output logic                         err
);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CW-1:0]    r_count;

    logic             w_pop;
    logic             w_push;
    logic             w_ovf;
    logic [CW:0]      w_ret;

    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign count     = r_count;

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    always_comb begin
        w_pop  = out_valid & out_ready;
        w_push = pipe_valid & ((r_count < CW'(DEPTH)) | w_pop);
        w_ovf  = pipe_valid & ~w_push & ~flush;
        // Flush returns every stored credit plus the one of a word dropped on arrival.
        if (flush)
            w_ret = {1'b0, r_count} + (CW+1)'(pipe_valid);
        else
            w_ret = (CW+1)'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_count  <= '0;
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_push)
                r_wr_ptr <= PTR_W'(wrap_inc(int'(r_wr_ptr), DEPTH));
            if (w_pop)
                r_rd_ptr <= PTR_W'(wrap_inc(int'(r_rd_ptr), DEPTH));
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_push && !flush)
            r_mem[r_wr_ptr] <= pipe_data;
    end

    pipe_drain_credit #(.DEPTH(DEPTH)) u_credit (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .ret         (w_ret),
        .ovf         (w_ovf),
        .issue_ok    (issue_ok),
        .credits     (credits),
        .err         (err)
    );

endmodule

// File: tb/tb_pipe_drain_buffer.sv
// Directed + random bench: models a 3-stage issue pipe feeding pipe_drain_buffer.
module tb_pipe_drain_buffer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       issue_valid = 1'b0;
    logic [7:0] issue_data = '0;
    logic       issue_ok;
    logic       pipe_valid;
    logic [7:0] pipe_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] count;
    logic [2:0] credits;
    logic       err;

    logic       inj_v = 1'b0;
    logic [7:0] inj_d = '0;
    logic [2:0] pv;
    logic [7:0] pd [3];

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] seq = 8'h01;
    logic [7:0] q [$];

    always #5 clk = ~clk;

    // Fixed-latency issue pipe: issue in cycle N emerges in cycle N+3.
    always_ff @(posedge clk) begin
        if (!rst_n) pv <= '0;
        else        pv <= {pv[1:0], issue_valid & issue_ok};
        pd[0] <= issue_data;
        pd[1] <= pd[0];
        pd[2] <= pd[1];
    end
    assign pipe_valid = pv[2] | inj_v;
    assign pipe_data  = inj_v ? inj_d : pd[2];

    pipe_drain_buffer #(.WIDTH(8), .DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_ok    (issue_ok),
        .pipe_valid  (pipe_valid),
        .pipe_data   (pipe_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .flush       (flush),
        .count       (count),
        .credits     (credits),
        .err         (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_cred"}, credits, 4);
        chk({tag, "_ok"}, issue_ok, 1);
        chk({tag, "_ov"}, out_valid, 0);
        chk({tag, "_od"}, out_data, 0);
        chk({tag, "_cnt"}, count, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // One random cycle: invariant, scoreboard pop, optional issue.
    task automatic rstep(input bit en);
        logic [7:0] exp;
        int         inf;
        inf = int'(pv[0]) + int'(pv[1]) + int'(pv[2]);
        chk("inv", int'(credits) + int'(count) + inf, 4);
        out_ready   = !en || ($urandom_range(0, 1) == 1);
        issue_valid = en && issue_ok && ($urandom_range(0, 1) == 1);
        issue_data  = seq;
        if (out_valid && out_ready) begin
            exp = (q.size() != 0) ? q.pop_front() : 8'hxx;
            chk("rdata", out_data, exp);
        end
        if (issue_valid) begin
            q.push_back(seq);
            seq++;
        end
        tick();
    endtask

    initial begin
        do_reset();
        chk_idle("rst");

        for (int i = 0; i < 4; i++) begin
            issue_valid = 1'b1;
            issue_data  = 8'(17 * (i + 1));
            tick();
            chk("cred_dec", credits, 3 - i);
        end
        issue_valid = 1'b0;
        chk("ok_zero", issue_ok, 0);
        repeat (3) tick();
        chk("full_cnt", count, 4);
        chk("full_ov", out_valid, 1);
        chk("full_head", out_data, 8'h11);

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pop_head", out_data, 8'h22);
        chk("pop_cred", credits, 1);
        chk("pop_cnt", count, 3);

        issue_valid = 1'b1;
        issue_data  = 8'h55;
        tick();
        issue_valid = 1'b0;
        chk("iss_cred", credits, 0);
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pp_cnt", count, 3);
        chk("pp_head", out_data, 8'h33);
        chk("pp_cred", credits, 1);
        chk("pp_err", err, 0);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_cnt", count, 0);
        chk("fl_ov", out_valid, 0);
        chk("fl_cred", credits, 4);
        chk("fl_err", err, 0);

        // Flush while a word arrives and another is still in flight.
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1'b1;
            issue_data  = 8'(8'h66 + 8'(17 * i));
            tick();
        end
        issue_valid = 1'b0;
        chk("fi_cred", credits, 1);
        tick();
        chk("fi_cnt1", count, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fi_cnt0", count, 0);
        chk("fi_cred3", credits, 3);
        tick();
        chk("fi_late_cnt", count, 1);
        chk("fi_late_d", out_data, 8'h88);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("fi_cred4", credits, 4);

        for (int i = 0; i < 10000; i++) rstep(1'b1);
        for (int i = 0; i < 16; i++) rstep(1'b0);
        out_ready = 1'b0;
        chk("rq_empty", q.size(), 0);
        chk("rcnt", count, 0);
        chk("rcred", credits, 4);

        // Boundary pushes at full, injected past the credit scheme.
        for (int i = 0; i < 4; i++) begin
            issue_valid = 1'b1;
            issue_data  = 8'(8'hA1 + i);
            tick();
        end
        issue_valid = 1'b0;
        repeat (3) tick();
        chk("inj_full", count, 4);
        inj_v = 1'b1;
        inj_d = 8'h99;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("inj_pp_cnt", count, 4);
        chk("inj_pp_head", out_data, 8'hA2);
        chk("inj_pp_err", err, 0);
        tick();
        inj_v = 1'b0;
        chk("inj_drop_err", err, 1);
        chk("inj_drop_cnt", count, 4);
        chk("inj_drop_head", out_data, 8'hA2);

        do_reset();
        chk_idle("rst2");

        for (int i = 0; i < 4; i++) begin
            issue_valid = 1'b1;
            issue_data  = 8'(8'hB0 + i);
            tick();
        end
        chk("z_ok", issue_ok, 0);
        tick();
        issue_valid = 1'b0;
        chk("z_cred", credits, 0);
        chk("z_err", err, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("z_data", out_data, 8'(8'hB0 + i));
            tick();
        end
        out_ready = 1'b0;
        chk("z_cnt", count, 0);
        chk("z_cred4", credits, 4);
        chk("z_sticky", err, 1);

        do_reset();
        chk("rst3_err", err, 0);
        chk("rst3_cred", credits, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
